// File: rtl/imm_ext_pipe.sv
// Immediate generator (I/S/B/J/U/zimm/shamt) for decode, 1-cycle latency, 2-entry skid buffer, registered in_ready.
// Define IMM_ERR_EN to add out_err, which flags reserved format 111 and travels with its entry.
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ERR_EN
    ,
    output logic             out_err
`endif
);

    // in_instr carries instruction bits [31:7]; keep the original bit numbering
    logic [31:7]      w_ins;
    logic [5:0]       w_shamt;
    logic [31:0]      w_raw;
    logic [XLEN-1:0]  w_imm;

    assign w_ins   = in_instr;
    assign w_shamt = (XLEN == 64) ? w_ins[25:20] : {1'b0, w_ins[24:20]};

    always_comb begin
        w_raw = 32'b0;
        case (in_imm_src)
            3'b000: w_raw = {{20{w_ins[31]}}, w_ins[31:20]};
            3'b001: w_raw = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            3'b010: w_raw = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            3'b011: w_raw = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            3'b100: w_raw = {w_ins[31:12], 12'b0};
            3'b101: w_raw = {27'b0, w_ins[19:15]};
            3'b110: w_raw = {26'b0, w_shamt};
            default: w_raw = 32'b0;
        endcase
    end

    // Zero-extended formats have bit 31 clear, so one sign-extension covers every format
    assign w_imm = XLEN'(signed'(w_raw));

    logic             r_main_vld;
    logic             r_skid_vld;
    logic             r_in_rdy;
    logic [XLEN-1:0]  r_main_imm;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic [TAG_W-1:0] r_skid_tag;

    logic w_acc;
    logic w_fire;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;
    logic w_main_vld_nxt;
    logic w_skid_vld_nxt;

    assign w_acc          = in_valid && r_in_rdy && !flush;
    assign w_fire         = r_main_vld && out_ready;
    assign w_ld_main_in   = w_acc && (!r_main_vld || (w_fire && !r_skid_vld));
    assign w_ld_skid      = w_acc && !w_ld_main_in;
    assign w_ld_main_skid = w_fire && r_skid_vld;
    assign w_main_vld_nxt = w_ld_main_in || w_ld_main_skid || (r_main_vld && !w_fire);
    assign w_skid_vld_nxt = w_ld_skid || (r_skid_vld && !w_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_main_imm <= '0;
            r_skid_imm <= '0;
            r_main_tag <= '0;
            r_skid_tag <= '0;
        end else if (flush) begin
            // Squash drops occupancy only; stale data stays but is never presented
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else begin
            r_main_vld <= w_main_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_in_rdy   <= !w_skid_vld_nxt;
            if (w_ld_main_in) begin
                r_main_imm <= w_imm;
                r_main_tag <= in_tag;
            end else if (w_ld_main_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
            end
            if (w_ld_skid) begin
                r_skid_imm <= w_imm;
                r_skid_tag <= in_tag;
            end
        end
    end

`ifdef IMM_ERR_EN
    logic r_main_err;
    logic r_skid_err;
    logic w_err;

    assign w_err = (in_imm_src == 3'b111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_err <= 1'b0;
            r_skid_err <= 1'b0;
        end else if (!flush) begin
            if (w_ld_main_in) begin
                r_main_err <= w_err;
            end else if (w_ld_main_skid) begin
                r_main_err <= r_skid_err;
            end
            if (w_ld_skid) begin
                r_skid_err <= w_err;
            end
        end
    end

    assign out_err = r_main_err;
`endif

    assign in_ready  = r_in_rdy;
    assign out_valid = r_main_vld;
    assign out_imm   = r_main_imm;
    assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench: two lockstep instances (XLEN=32 and XLEN=64) checked against an arithmetic reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] cur_ins;
    logic [24:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag32, out_tag64;
`ifdef IMM_ERR_EN
    logic        out_err32, out_err64;
`endif

    always #5 clk = ~clk;
    assign in_instr = cur_ins[31:7];

    imm_ext_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32)
`ifdef IMM_ERR_EN
        , .out_err(out_err32)
`endif
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64)
`ifdef IMM_ERR_EN
        , .out_err(out_err64)
`endif
    );

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;
    int   mis = 0;
    bit   sb_rdy = 1'b1;
    bit   last_acc = 1'b0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: immediates as signed integers built from weighted instruction fields
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit x64);
        longint v;
        v = 0;
        case (src)
            3'd0: begin v = ins[31:20]; if (ins[31]) v -= 4096; end
            3'd1: begin v = ins[31:25] * 32 + ins[11:7]; if (ins[31]) v -= 4096; end
            3'd2: begin v = ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2; if (ins[31]) v -= 4096; end
            3'd3: begin v = ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2; if (ins[31]) v -= longint'(1) << 20; end
            3'd4: begin v = longint'(ins[30:12]) * 4096; if (ins[31]) v -= longint'(1) << 31; end
            3'd5: v = ins[19:15];
            3'd6: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (x64) return v;
        return {32'b0, v[31:0]};
    endfunction

    // Model: accepts into the scoreboard on the clock edge
    always @(posedge clk) begin
        if (rst_n) begin
            last_acc = 1'b0;
            if (flush) begin
                sb.delete();
            end else if (in_valid && sb_rdy) begin
                exp_t e;
                e.imm32 = ref_imm(cur_ins, in_imm_src, 1'b0)[31:0];
                e.imm64 = ref_imm(cur_ins, in_imm_src, 1'b1);
                e.tag   = in_tag;
                e.err   = (in_imm_src == 3'd7);
                sb.push_back(e);
                last_acc = 1'b1;
            end
        end
    end

    always @(negedge rst_n) begin
        sb.delete();
        sb_rdy = 1'b1;
    end

    // Monitor: compares presented outputs and pops on handshake
    always @(negedge clk) begin
        if (rst_n && !done) begin
            chk("out_valid32", {63'b0, out_valid32}, {63'b0, sb.size() > 0});
            chk("out_valid64", {63'b0, out_valid64}, {63'b0, sb.size() > 0});
            chk("in_ready32", {63'b0, in_ready32}, {63'b0, sb.size() != 2});
            chk("in_ready64", {63'b0, in_ready64}, {63'b0, sb.size() != 2});
            sb_rdy = (sb.size() != 2);
            if (sb.size() > 0) begin
                chk("out_imm32", {32'b0, out_imm32}, {32'b0, sb[0].imm32});
                chk("out_imm64", out_imm64, sb[0].imm64);
                chk("out_tag32", {59'b0, out_tag32}, {59'b0, sb[0].tag});
                chk("out_tag64", {59'b0, out_tag64}, {59'b0, sb[0].tag});
`ifdef IMM_ERR_EN
                chk("out_err32", {63'b0, out_err32}, {63'b0, sb[0].err});
                chk("out_err64", {63'b0, out_err64}, {63'b0, sb[0].err});
`endif
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag,
                        input int maxc, output bit ok);
        in_valid   = 1'b1;
        cur_ins    = ins;
        in_imm_src = src;
        in_tag     = tag;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (last_acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input string nm, input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
        bit ok;
        send(ins, src, tag, 1, ok);
        chk(nm, {63'b0, ok}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_vld32"}, {63'b0, out_valid32}, 64'd0);
        chk({nm, "_vld64"}, {63'b0, out_valid64}, 64'd0);
        chk({nm, "_rdy32"}, {63'b0, in_ready32}, 64'd1);
        chk({nm, "_rdy64"}, {63'b0, in_ready64}, 64'd1);
        chk({nm, "_imm32"}, {32'b0, out_imm32}, 64'd0);
        chk({nm, "_imm64"}, out_imm64, 64'd0);
        chk({nm, "_tag32"}, {59'b0, out_tag32}, 64'd0);
`ifdef IMM_ERR_EN
        chk({nm, "_err32"}, {63'b0, out_err32}, 64'd0);
        chk({nm, "_err64"}, {63'b0, out_err64}, 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; cur_ins = '0;
        in_imm_src = '0; in_tag = '0; out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Every format back-to-back at full throughput
        out_ready = 1'b1;
        send_chk("acc_I",  32'hFFF00093, 3'd0, 5'd3);
        send_chk("acc_S",  32'hFE512E23, 3'd1, 5'd4);
        send_chk("acc_B",  32'hFE000CE3, 3'd2, 5'd5);
        send_chk("acc_J",  32'hFFDFF06F, 3'd3, 5'd6);
        send_chk("acc_U",  32'h123450B7, 3'd4, 5'd7);
        send_chk("acc_Z",  32'h000F8073, 3'd5, 5'd8);
        send_chk("acc_U64", 32'h800000B7, 3'd4, 5'd9);
        send_chk("acc_SH", 32'h03F00013, 3'd6, 5'd10);
        send_chk("acc_RSV", 32'hFFFFFFFF, 3'd7, 5'd11);
        repeat (3) tick();

        // Backpressure: two entries fill the buffer, the third is held off
        out_ready = 1'b0;
        send_chk("bp_a", 32'h00100093, 3'd0, 5'd12);
        send_chk("bp_b", 32'h80000537, 3'd4, 5'd13);
        send(32'h7FF00013, 3'd0, 5'd14, 3, ok);
        chk("bp_held", {63'b0, ok}, 64'd0);
        out_ready = 1'b1;
        send(32'h7FF00013, 3'd0, 5'd14, 4, ok);
        chk("bp_release", {63'b0, ok}, 64'd1);
        repeat (4) tick();

        // Flush with full buffer, then with in_ready high; flushed inputs must vanish
        out_ready = 1'b0;
        send_chk("fl_a", 32'h12345013, 3'd0, 5'd15);
        send_chk("fl_b", 32'h00500013, 3'd1, 5'd16);
        in_valid = 1'b1; cur_ins = 32'hABCDE0B7; in_imm_src = 3'd4; in_tag = 5'd17; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_full_drop", {63'b0, last_acc}, 64'd0);
        tick();
        send_chk("fl_c", 32'h00A00013, 3'd0, 5'd18);
        in_valid = 1'b1; cur_ins = 32'h00B00013; in_tag = 5'd19; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset while an entry is stalled at the output
        out_ready = 1'b0;
        send_chk("rst_a", 32'hFFF00093, 3'd0, 5'd20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomised traffic; upstream holds its entry until accepted
        for (int i = 0; i < 600; i++) begin
            if (!(in_valid && !last_acc && !flush)) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                cur_ins    = $urandom;
                in_imm_src = 3'($urandom_range(0, 7));
                in_tag     = 5'($urandom_range(0, 31));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
